acc_drain_requant: RTL and testbench

- Reader side of the PE accumulator interface. Snapshots the full ROWS×COLS array of `acc_out`/`overflow` values at tile end and pulses `clear_acc` so the array can start the next tile.
- Requantizes each 32-bit accumulator to signed ACT_WIDTH with scale, round and saturate.
- Streams results row-major over a valid/ready interface to the output buffer / next layer.

---
 rtl/acc_drain_requant_pkg.sv | 47 ++++
 rtl/acc_drain_requant_requant_stage.sv | 128 ++++++++++++
 rtl/acc_drain_requant.sv | 171 +++++++++++++++++
 tb/tb_acc_drain_requant.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_drain_requant_pkg.sv
// Shared types, widths and the saturation helper for the accumulator drain/requant path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_drain_requant_pkg;

    localparam int ACC_WIDTH   = 32;   // PE accumulator width
    localparam int ACT_WIDTH   = 8;    // requantized activation width
    localparam int REQ_SCALE_W = 16;   // unsigned requant multiplier width
    localparam int REQ_SHIFT_W = 5;    // right-shift amount width (0..31)

    // Saturation input is widened to a fixed size so any requant user can share it.
    localparam int SAT_IN_W = 64;

    localparam int ACT_MAX = (2 ** (ACT_WIDTH - 1)) - 1;
    localparam int ACT_MIN = -(2 ** (ACT_WIDTH - 1));

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = SAT_IN_W'(ACT_MAX);
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = SAT_IN_W'(ACT_MIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    typedef struct packed {
        logic                 sat;
        logic [ACT_WIDTH-1:0] data;
    } act_sat_t;

    // Clamp a signed value to the activation range and flag whether it clipped.
    function automatic act_sat_t sat_to_act(input logic signed [SAT_IN_W-1:0] v);
        act_sat_t r;
        if (v > SAT_MAX) begin
            r.sat  = 1'b1;
            r.data = ACT_WIDTH'(ACT_MAX);
        end else if (v < SAT_MIN) begin
            r.sat  = 1'b1;
            r.data = ACT_WIDTH'(ACT_MIN);
        end else begin
            r.sat  = 1'b0;
            r.data = v[ACT_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_drain_requant_requant_stage.sv
// Two-stage requant pipeline: S1 = signed(acc) x unsigned(scale), S2 = round, shift, saturate.
// Latency: 2 enabled cycles from in_vld_i to out_valid_o.
// Backpressure: both stages hold while en_i is low; S2 is the output register.
// Ports: en_i advance strobe; in_vld_i/acc_i/ovf_i/last_i issue slot; scale_i for S1,
//        shift_i (and zp_i when ACC_DRAIN_ZERO_POINT_EN is defined) for S2; out_* result beat.
module acc_drain_requant_requant_stage
    import acc_drain_requant_pkg::*;
#(
    parameter int SCALE_W = REQ_SCALE_W,
    parameter int SHIFT_W = REQ_SHIFT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic                        in_vld_i,
    input  logic [ACC_WIDTH-1:0]        acc_i,
    input  logic                        ovf_i,
    input  logic                        last_i,
    input  logic [SCALE_W-1:0]          scale_i,
    input  logic [SHIFT_W-1:0]          shift_i,
`ifdef ACC_DRAIN_ZERO_POINT_EN
    input  logic signed [ACT_WIDTH-1:0] zp_i,
`endif
    output logic signed [ACT_WIDTH-1:0] out_data_o,
    output logic                        out_valid_o,
    output logic                        out_last_o,
    output logic                        out_sat_o
);

    // One extra bit so the unsigned scale can be treated as a signed operand.
    localparam int PROD_W = ACC_WIDTH + SCALE_W + 1;

    logic signed [PROD_W-1:0] acc_x;
    logic signed [PROD_W-1:0] scl_x;
    logic signed [PROD_W-1:0] prod_d;

    logic                     s1_vld_q;
    logic signed [PROD_W-1:0] s1_prod_q;
    logic                     s1_ovf_q;
    logic                     s1_neg_q;
    logic                     s1_last_q;

    logic signed [PROD_W-1:0]   rnd;
    logic signed [PROD_W-1:0]   sum;
    logic signed [PROD_W-1:0]   q;
    logic signed [SAT_IN_W-1:0] q_ext;
    act_sat_t                   r;
    logic [ACT_WIDTH-1:0]       s2_data_d;
    logic                       s2_sat_d;

`ifdef ACC_DRAIN_ZERO_POINT_EN
    localparam logic signed [SAT_IN_W-1:0] SAT9_MAX = SAT_IN_W'((2 ** ACT_WIDTH) - 1);
    localparam logic signed [SAT_IN_W-1:0] SAT9_MIN = SAT_IN_W'(-(2 ** ACT_WIDTH));
    logic signed [ACT_WIDTH:0]   q9;
    logic                        clip9;
    logic signed [ACT_WIDTH+1:0] zsum;
`endif

    always_comb begin
        acc_x  = {{(PROD_W-ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
        scl_x  = {{(PROD_W-SCALE_W){1'b0}}, scale_i};
        prod_d = acc_x * scl_x;
    end

    always_comb begin
        // Half-LSB bias before the arithmetic shift gives round-half-up toward +inf.
        if (shift_i == '0) begin
            rnd = '0;
        end else begin
            rnd = PROD_W'(1) << (shift_i - SHIFT_W'(1));
        end
        sum   = s1_prod_q + rnd;
        q     = sum >>> shift_i;
        q_ext = SAT_IN_W'(q);
`ifdef ACC_DRAIN_ZERO_POINT_EN
        // Pre-clamp to one bit wider than the activation so the zero-point add
        // fits in ACT_WIDTH+2 bits; anything clipped here would clip afterwards too.
        clip9 = 1'b0;
        if (q_ext > SAT9_MAX) begin
            q9    = (ACT_WIDTH+1)'((2 ** ACT_WIDTH) - 1);
            clip9 = 1'b1;
        end else if (q_ext < SAT9_MIN) begin
            q9    = (ACT_WIDTH+1)'(-(2 ** ACT_WIDTH));
            clip9 = 1'b1;
        end else begin
            q9 = q_ext[ACT_WIDTH:0];
        end
        zsum      = {q9[ACT_WIDTH], q9} + {{2{zp_i[ACT_WIDTH-1]}}, zp_i};
        r         = sat_to_act(SAT_IN_W'(zsum));
        s2_data_d = r.data;
        s2_sat_d  = r.sat | clip9;
`else
        r         = sat_to_act(q_ext);
        s2_data_d = r.data;
        s2_sat_d  = r.sat;
`endif
        // A PE overflow makes the accumulator meaningless; pin to the rail of its sign.
        if (s1_ovf_q) begin
            s2_data_d = s1_neg_q ? ACT_WIDTH'(ACT_MIN) : ACT_WIDTH'(ACT_MAX);
            s2_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_prod_q   <= '0;
            s1_ovf_q    <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_sat_o   <= 1'b0;
        end else if (en_i) begin
            s1_vld_q    <= in_vld_i;
            s1_prod_q   <= prod_d;
            s1_ovf_q    <= ovf_i;
            s1_neg_q    <= acc_i[ACC_WIDTH-1];
            s1_last_q   <= last_i;
            out_valid_o <= s1_vld_q;
            out_data_o  <= s2_data_d;
            out_last_o  <= s1_last_q;
            out_sat_o   <= s2_sat_d;
        end
    end

endmodule

// File: rtl/acc_drain_requant.sv
// Snapshots the PE accumulator array at tile end, clears it, and streams requantized results row-major.
// Latency: start in cycle T -> clear_acc/busy in T+1 -> first out_valid in T+2; 1 beat/cycle after.
// Backpressure: valid/ready; the whole pipeline and issue index hold while out_valid && !out_ready.
// Ports: start/acc_in/ovf_in/scale/shift (+ zp under ACC_DRAIN_ZERO_POINT_EN) sampled on accepted start;
//        clear_acc pulse to the array; busy/done status; out_data/out_valid/out_ready/out_last/out_sat stream.
module acc_drain_requant
    import acc_drain_requant_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int SCALE_W = REQ_SCALE_W,
    parameter int SHIFT_W = REQ_SHIFT_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0]  acc_in,
    input  logic [ROWS*COLS-1:0]            ovf_in,
    input  logic [SCALE_W-1:0]              scale,
    input  logic [SHIFT_W-1:0]              shift,
`ifdef ACC_DRAIN_ZERO_POINT_EN
    input  logic signed [ACT_WIDTH-1:0]     zp,
`endif
    output logic                            clear_acc,
    output logic                            busy,
    output logic                            done,
    output logic signed [ACT_WIDTH-1:0]     out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            out_sat
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_e         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ACC_WIDTH-1:0] acc_q [N];
    logic [N-1:0]         ovf_q;
    logic [SCALE_W-1:0]   scale_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic                 clear_q, clear_d;
    logic                 done_q, done_d;
    logic                 snap;
`ifdef ACC_DRAIN_ZERO_POINT_EN
    logic signed [ACT_WIDTH-1:0] zp_q;
`endif

    logic                 adv;
    logic                 iss_vld;
    logic [ACC_WIDTH-1:0] iss_acc;
    logic                 iss_ovf;
    logic                 iss_last;
    logic [SCALE_W-1:0]   iss_scale;

    assign adv       = out_ready || !out_valid;
    assign busy      = (state_q != IDLE);
    assign clear_acc = clear_q;
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clear_d   = 1'b0;
        done_d    = 1'b0;
        snap      = 1'b0;
        iss_vld   = 1'b0;
        iss_acc   = acc_q[idx_q];
        iss_ovf   = ovf_q[idx_q];
        iss_scale = scale_q;
        iss_last  = (idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                // Element 0 bypasses the shadow and enters S1 on the snapshot edge,
                // so the first beat appears one cycle after clear_acc. The pipeline
                // is always empty in IDLE, so the stage is enabled here.
                if (start) begin
                    snap      = 1'b1;
                    clear_d   = 1'b1;
                    iss_vld   = 1'b1;
                    iss_acc   = acc_in[ACC_WIDTH-1:0];
                    iss_ovf   = ovf_in[0];
                    iss_scale = scale;
                    iss_last  = (N == 1);
                    idx_d     = (N == 1) ? '0 : IDX_W'(1);
                    state_d   = (N == 1) ? FLUSH : DRAIN;
                end
            end
            DRAIN: begin
                iss_vld = 1'b1;
                if (adv) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FLUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (out_valid && out_ready && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            clear_q <= clear_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q   <= '0;
            scale_q <= '0;
            shift_q <= '0;
`ifdef ACC_DRAIN_ZERO_POINT_EN
            zp_q    <= '0;
`endif
        end else if (snap) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
            end
            ovf_q   <= ovf_in;
            scale_q <= scale;
            shift_q <= shift;
`ifdef ACC_DRAIN_ZERO_POINT_EN
            zp_q    <= zp;
`endif
        end
    end

    acc_drain_requant_requant_stage #(
        .SCALE_W (SCALE_W),
        .SHIFT_W (SHIFT_W)
    ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (adv),
        .in_vld_i    (iss_vld),
        .acc_i       (iss_acc),
        .ovf_i       (iss_ovf),
        .last_i      (iss_last),
        .scale_i     (iss_scale),
        .shift_i     (shift_q),
`ifdef ACC_DRAIN_ZERO_POINT_EN
        .zp_i        (zp_q),
`endif
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .out_sat_o   (out_sat)
    );

endmodule

// File: tb/tb_acc_drain_requant.sv
// Directed bench for acc_drain_requant: reset, latency, requant arithmetic, overflow forcing,
// backpressure stability, ignored mid-drain start and reset abort.
// Drives at posedge+1, samples at posedge+1.
module tb_acc_drain_requant;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [N*32-1:0]     acc_in;
    logic [N-1:0]        ovf_in;
    logic [15:0]         scale;
    logic [4:0]          shift;
    logic                clear_acc, busy, done;
    logic signed [7:0]   out_data;
    logic                out_valid, out_ready, out_last, out_sat;

    int                  n_assert = 0;
    int                  n_fail   = 0;
    int                  acc_v [N];
    logic [N-1:0]        ovf_v;
    logic signed [7:0]   exp_d [N];
    logic                exp_s [N];
    logic [7:0]          got_d [N];
    logic                got_s [N];
    logic                got_l [N];
    int                  nbeats;

    always #5 clk = ~clk;

    acc_drain_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_in    (acc_in),
        .ovf_in    (ovf_in),
        .scale     (scale),
        .shift     (shift),
        .clear_acc (clear_acc),
        .busy      (busy),
        .done      (done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents the vector, pulses start, then scrambles inputs to prove the snapshot.
    task automatic do_start(input int sc, input int sh);
        for (int i = 0; i < N; i++) acc_in[i*32 +: 32] = acc_v[i];
        ovf_in = ovf_v;
        scale  = 16'(sc);
        shift  = 5'(sh);
        start  = 1'b1;
        step();
        start  = 1'b0;
        acc_in = {N{32'h7777_0000}};
        ovf_in = '1;
        scale  = 16'hffff;
        shift  = 5'd31;
        chk("clr_T1", clear_acc, 1);
        chk("busy_T1", busy, 1);
        chk("vld_T1", out_valid, 0);
        chk("done_T1", done, 0);
        step();
        chk("clr_T2", clear_acc, 0);
        chk("vld_T2", out_valid, 1);
    endtask

    task automatic run_drain(input int ready_pct, input int mid_start_beat, input int abort_beat);
        int k = 0;
        int cyc = 0;
        bit stalled = 0, seen_last = 0, pulsed = 0, pulsed_prev = 0;
        logic [7:0] pd;
        logic ps, pl;
        pd = '0; ps = 1'b0; pl = 1'b0;
        for (int i = 0; i < N; i++) begin
            got_d[i] = 'x; got_s[i] = 1'bx; got_l[i] = 1'bx;
        end
        while (!seen_last && cyc < 400 && k != abort_beat) begin
            if (stalled) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_dat", {24'b0, out_data}, {24'b0, pd});
                chk("stall_sat", out_sat, ps);
                chk("stall_last", out_last, pl);
            end
            if (ready_pct == 100) chk("no_bubble", out_valid, 1);
            chk("no_early_done", done, 0);
            if (pulsed_prev) begin
                chk("mid_start_clr", clear_acc, 0);
                chk("mid_start_busy", busy, 1);
                pulsed_prev = 0;
            end
            start = 1'b0;
            if (k == mid_start_beat && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
                pulsed_prev = 1;
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid && out_ready) begin
                if (k < N) begin
                    got_d[k] = out_data;
                    got_s[k] = out_sat;
                    got_l[k] = out_last;
                end
                if (out_last) seen_last = 1;
                k++;
            end
            stalled = out_valid && !out_ready;
            pd = out_data; ps = out_sat; pl = out_last;
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        nbeats = k;
        if (abort_beat < 0) begin
            chk("drain_budget", cyc < 400, 1);
            chk("done_pulse", done, 1);
            chk("busy_at_done", busy, 0);
            chk("vld_empty", out_valid, 0);
        end
    endtask

    task automatic check_beats();
        chk("beat_count", nbeats, N);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("data%0d", i), {24'b0, got_d[i]}, {24'b0, exp_d[i]});
            chk($sformatf("sat%0d", i), got_s[i], exp_s[i]);
            chk($sformatf("last%0d", i), got_l[i], (i == N - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        acc_in = '0; ovf_in = '0; scale = '0; shift = '0;
        repeat (2) step();
        chk("rst_vld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr", clear_acc, 0);
        chk("rst_done", done, 0);
        chk("rst_data", {24'b0, out_data}, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", out_sat, 0);
        rst_n = 1'b1;
        step();

        // All 100, unity scale.
        ovf_v = '0;
        for (int i = 0; i < N; i++) begin acc_v[i] = 100; exp_d[i] = 8'sd100; exp_s[i] = 1'b0; end
        do_start(1, 0);
        run_drain(100, -1, -1);
        check_beats();

        // Saturation and overflow forcing; started in the done cycle.
        for (int i = 0; i < N; i++) begin acc_v[i] = i; exp_d[i] = 8'(i); exp_s[i] = 1'b0; end
        acc_v[0] = 1000;  exp_d[0] = 127;  exp_s[0] = 1'b1;
        acc_v[1] = -1000; exp_d[1] = -128; exp_s[1] = 1'b1;
        acc_v[2] = -128;  exp_d[2] = -128; exp_s[2] = 1'b0;
        acc_v[3] = 127;   exp_d[3] = 127;  exp_s[3] = 1'b0;
        acc_v[4] = 128;   exp_d[4] = 127;  exp_s[4] = 1'b1;
        acc_v[5] = -5;    exp_d[5] = -128; exp_s[5] = 1'b1;
        acc_v[6] = -129;  exp_d[6] = -128; exp_s[6] = 1'b1;
        acc_v[7] = 50;    exp_d[7] = 127;  exp_s[7] = 1'b1;
        ovf_v = 16'h00A0;
        do_start(1, 0);
        run_drain(100, -1, -1);
        check_beats();

        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);

        // Scale 3, shift 2: rounding half up toward +inf.
        ovf_v = '0;
        for (int i = 0; i < N; i++) begin acc_v[i] = 0; exp_d[i] = 0; exp_s[i] = 1'b0; end
        acc_v[0] = 7;    exp_d[0] = 5;
        acc_v[1] = -6;   exp_d[1] = -4;
        acc_v[2] = 1;    exp_d[2] = 1;
        acc_v[3] = -1;   exp_d[3] = -1;
        acc_v[4] = 2;    exp_d[4] = 2;
        acc_v[5] = 100;  exp_d[5] = 75;
        acc_v[6] = -100; exp_d[6] = -75;
        acc_v[7] = 200;  exp_d[7] = 127;  exp_s[7] = 1'b1;
        acc_v[8] = -200; exp_d[8] = -128; exp_s[8] = 1'b1;
        acc_v[9] = -2;   exp_d[9] = -1;
        do_start(3, 2);
        run_drain(100, -1, -1);
        check_beats();

        // Scale 1, shift 2 under 30% ready with an ignored mid-drain start.
        acc_v[0] = -6; exp_d[0] = -1; exp_s[0] = 1'b0;
        for (int i = 1; i < N; i++) begin acc_v[i] = 8 * i - 64; exp_d[i] = 8'(2 * i - 16); exp_s[i] = 1'b0; end
        do_start(1, 2);
        run_drain(30, 5, -1);
        check_beats();

        // Reset at beat 7 aborts the drain.
        for (int i = 0; i < N; i++) acc_v[i] = 3 * i;
        do_start(1, 0);
        run_drain(100, -1, 7);
        chk("abort_beats", nbeats, 7);
        rst_n = 1'b0;
        #1;
        chk("abort_vld", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_clr", clear_acc, 0);
        chk("abort_done", done, 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_abort_done", done, 0);
            chk("post_abort_vld", out_valid, 0);
        end

        // Fresh snapshot after the abort.
        for (int i = 0; i < N; i++) begin acc_v[i] = i - 8; exp_d[i] = 8'(i - 8); exp_s[i] = 1'b0; end
        do_start(1, 0);
        run_drain(100, -1, -1);
        check_beats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
